// File: rtl/bus_ctrl_pkg.sv
// Shared definitions for the bus transfer controller: default sizing,
// controller state encoding and the request field layout.
package bus_ctrl_pkg;

  localparam int NREG_DEF = 8;
  localparam int SELW_DEF = 3;
  // Register-select fields are carried zero-extended to this width.
  localparam int SELW_MAX = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_LATCH  = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_REJECT = 3'd4
  } state_t;

  typedef struct packed {
    logic                id;
    logic                clr;
    logic [SELW_MAX-1:0] src;
    logic [SELW_MAX-1:0] dst;
  } req_t;

  // A request is illegal if it names a register that does not exist, or if
  // a copy would read and write the same register.
  function automatic logic req_legal(input req_t r, input int nreg);
    logic ok;
    ok = 1'b1;
    if (int'(r.dst) >= nreg) ok = 1'b0;
    if (!r.clr && ((int'(r.src) >= nreg) || (r.src == r.dst))) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from valid; the
// priority pointer only moves when the owner actually accepts the grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       last_grant
);

  // Pick the single requester, or the one not served last on contention.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember who was served; starts at 1 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant <= 1'b1;
    else if (accept) last_grant <= grant[1];
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Sequences register-to-register transfers over the shared tri-state bus.
// Only one register ever drives the bus; all strobes decode from registered
// state so requester inputs never reach the strobes combinationally.
module bus_xfer_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int SELW = SELW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [SELW-1:0] req0_src,
  input  logic [SELW-1:0] req0_dst,
  input  logic            req0_clr,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [SELW-1:0] req1_src,
  input  logic [SELW-1:0] req1_dst,
  input  logic            req1_clr,
  output logic            req1_ready,
  output logic [NREG-1:0] rd_en,
  output logic [NREG-1:0] wr_en,
  output logic [NREG-1:0] clr_en,
  output logic [NREG-1:0] reg_en,
  output logic            busy,
  output logic            done,
  output logic            done_id,
  output logic            err
);

  state_t          state, state_nx;
  logic [1:0]      valid, grant;
  logic            last_grant, accept;
  req_t            req_sel;
  logic            cap_id, cap_clr;
  logic [SELW-1:0] cap_src, cap_dst;
  logic [NREG-1:0] src_oh, dst_oh;

  assign valid = {req1_valid, req0_valid};

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .accept     (accept),
    .grant      (grant),
    .last_grant (last_grant)
  );

  assign accept     = (state == ST_IDLE) && (|grant);
  assign req0_ready = (state == ST_IDLE) && grant[0];
  assign req1_ready = (state == ST_IDLE) && grant[1];

  // Mux the winning requester's fields into the common request layout.
  always_comb begin
    req_sel.id  = grant[1];
    req_sel.clr = req0_clr;
    req_sel.src = SELW_MAX'(req0_src);
    req_sel.dst = SELW_MAX'(req0_dst);
    if (grant[1]) begin
      req_sel.clr = req1_clr;
      req_sel.src = SELW_MAX'(req1_src);
      req_sel.dst = SELW_MAX'(req1_dst);
    end
  end

  // Control state: FSM state and the owner of the transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cap_id <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) cap_id <= req_sel.id;
    end
  end

  // Request fields are sampled only on accept; they only matter while busy.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_clr <= req_sel.clr;
      cap_src <= req_sel.src[SELW-1:0];
      cap_dst <= req_sel.dst[SELW-1:0];
    end
  end

  // One-hot decode of the captured register selects.
  always_comb begin
    src_oh = '0;
    dst_oh = '0;
    for (int i = 0; i < NREG; i++) begin
      src_oh[i] = (cap_src == SELW'(i));
      dst_oh[i] = (cap_dst == SELW'(i));
    end
  end

  // Next state and strobes; the bus is driven a cycle before it is latched.
  always_comb begin
    state_nx = state;
    rd_en    = '0;
    wr_en    = '0;
    clr_en   = '0;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!req_legal(req_sel, NREG)) state_nx = ST_REJECT;
          else if (req_sel.clr)          state_nx = ST_CLEAR;
          else                           state_nx = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        rd_en    = src_oh;
        state_nx = ST_LATCH;
      end
      ST_LATCH: begin
        rd_en    = src_oh;
        wr_en    = dst_oh;
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      ST_CLEAR: begin
        clr_en   = dst_oh;
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      ST_REJECT: begin
        done     = 1'b1;
        err      = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign reg_en  = rd_en | wr_en | clr_en;
  assign busy    = (state != ST_IDLE);
  assign done_id = cap_id;

endmodule
